// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared state encoding and geometry helpers for the
// cache block fill responder (cache_fill_fsm and fill_counter).
package cache_fill_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   localparam int BLOCK_WORDS_DEF  = 8;
   localparam int OFFSET_BITS      = $clog2(BLOCK_WORDS_DEF);
   // one extra low bit selects the byte inside a 16-bit word
   localparam int BYTE_OFFSET_BITS = OFFSET_BITS + 1;

   function automatic int offset_bits(input int block_words);
      return $clog2(block_words);
   endfunction

   function automatic int tag_width(input int addr_w,
                                    input int block_words);
      return addr_w - $clog2(block_words) - 1;
   endfunction

endpackage

// File: rtl/fill_counter.sv
// fill_counter: enable-driven up-counter with synchronous clear and a
// block-offset output that wraps modulo the block size.
// Ports: clk, rst (sync, active high), i_clr, i_en, i_start (start
// offset), o_cnt (raw count), o_off (i_start + count, wrapped).
module fill_counter
   import cache_fill_pkg::*;
#(
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
   localparam int OB = offset_bits(BLOCK_WORDS),
   localparam int CB = OB + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic [OB-1:0] i_start,
   output logic [CB-1:0] o_cnt,
   output logic [OB-1:0] o_off
);

   logic [CB-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CB'(1);
      end
   end

   assign o_cnt = r_cnt;
   // the offset field is OB bits wide, so the add wraps by itself
   assign o_off = i_start + r_cnt[OB-1:0];

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one cache block from multi-cycle memory on a
// miss, streams words into the data array, then writes the tag.
// Ports: clk, rst (sync, active high); miss_detected/miss_address in;
// fsm_busy out; memory_read_en/memory_address out; memory_data/
// memory_data_valid in; write_data_array, array_addr, array_wdata,
// write_tag_array, tag_out, critical_word_valid out.
// Option: define CACHE_FILL_CRITICAL_WORD_FIRST_EN to issue and fill
// starting at the missed word, wrapping around the block.
module cache_fill_fsm
   import cache_fill_pkg::*;
#(
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
   parameter int MEM_LATENCY = 4,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   localparam int OB = offset_bits(BLOCK_WORDS),
   localparam int CB = OB + (BYTE_OFFSET_BITS - OFFSET_BITS),
   localparam int TW = tag_width(ADDR_W, BLOCK_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              fsm_busy,
   output logic              memory_read_en,
   output logic [ADDR_W-1:0] memory_address,
   input  logic [DATA_W-1:0] memory_data,
   input  logic              memory_data_valid,
   output logic              write_data_array,
   output logic [ADDR_W-1:0] array_addr,
   output logic [DATA_W-1:0] array_wdata,
   output logic              write_tag_array,
   output logic [TW-1:0]     tag_out,
   output logic              critical_word_valid
);

   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << CB) - 1);

   fill_state_e       r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_base, w_base_nxt;
   logic [OB-1:0]     r_crit, w_crit_nxt;

   logic [CB-1:0]     w_issue_cnt, w_recv_cnt;
   logic [OB-1:0]     w_issue_off, w_recv_off;
   logic [OB-1:0]     w_start;
   logic              w_issue_en, w_recv_en, w_last;

   // return timing is set by memory_data_valid, not by a local timer
   logic [31:0]       w_unused_latency;
   assign w_unused_latency = 32'(MEM_LATENCY);

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   assign w_start = r_crit;
`else
   assign w_start = '0;
`endif

   assign w_issue_en = (r_state == FILL) &&
                       (w_issue_cnt < CB'(BLOCK_WORDS));
   assign w_recv_en  = (r_state == FILL) && memory_data_valid;
   assign w_last     = w_recv_en &&
                       (w_recv_cnt == CB'(BLOCK_WORDS - 1));

   fill_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_issue (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_last),
      .i_en    (w_issue_en),
      .i_start (w_start),
      .o_cnt   (w_issue_cnt),
      .o_off   (w_issue_off)
   );

   fill_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_recv (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_last),
      .i_en    (w_recv_en),
      .i_start (w_start),
      .o_cnt   (w_recv_cnt),
      .o_off   (w_recv_off)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_crit  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_base  <= w_base_nxt;
         r_crit  <= w_crit_nxt;
      end
   end

   always_comb begin
      w_state_nxt         = r_state;
      w_base_nxt          = r_base;
      w_crit_nxt          = r_crit;
      memory_read_en      = 1'b0;
      memory_address      = '0;
      write_data_array    = 1'b0;
      array_addr          = '0;
      write_tag_array     = 1'b0;
      tag_out             = '0;
      critical_word_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (miss_detected) begin
               w_state_nxt = FILL;
               w_base_nxt  = miss_address & ~LOW_MASK;
               w_crit_nxt  = miss_address[OB:1];
            end
         end
         FILL: begin
            memory_read_en = w_issue_en;
            if (w_issue_en) begin
               memory_address = r_base +
                  ADDR_W'({w_issue_off, 1'b0});
            end
            write_data_array = w_recv_en;
            if (w_recv_en) begin
               array_addr = r_base +
                  ADDR_W'({w_recv_off, 1'b0});
               critical_word_valid = (w_recv_off == r_crit);
            end
            if (w_last) begin
               write_tag_array = 1'b1;
               tag_out         = r_base[ADDR_W-1:CB];
               w_state_nxt     = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign fsm_busy    = (r_state == FILL);
   assign array_wdata = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fill table, reset and random checks of
// cache_fill_fsm against a latency-based memory and reference model.
module tb_cache_fill_fsm;
   import cache_fill_pkg::*;

   localparam int BW = 8;
   localparam int ML = 4;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TW = AW - 3 - 1;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          miss_detected;
   logic [AW-1:0] miss_address;
   logic          fsm_busy;
   logic          memory_read_en;
   logic [AW-1:0] memory_address;
   logic [DW-1:0] memory_data;
   logic          memory_data_valid;
   logic          write_data_array;
   logic [AW-1:0] array_addr;
   logic [DW-1:0] array_wdata;
   logic          write_tag_array;
   logic [TW-1:0] tag_out;
   logic          critical_word_valid;

   int checks = 0;
   int failures = 0;

   cache_fill_fsm #(
      .BLOCK_WORDS (BW),
      .MEM_LATENCY (ML),
      .ADDR_W      (AW),
      .DATA_W      (DW)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .miss_detected       (miss_detected),
      .miss_address        (miss_address),
      .fsm_busy            (fsm_busy),
      .memory_read_en      (memory_read_en),
      .memory_address      (memory_address),
      .memory_data         (memory_data),
      .memory_data_valid   (memory_data_valid),
      .write_data_array    (write_data_array),
      .array_addr          (array_addr),
      .array_wdata         (array_wdata),
      .write_tag_array     (write_tag_array),
      .tag_out             (tag_out),
      .critical_word_valid (critical_word_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   // memory: data for a request appears ML cycles later
   logic          pv [ML];
   logic [AW-1:0] pa [ML];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ML; i++) begin
            pv[i] <= 1'b0;
            pa[i] <= '0;
         end
      end else begin
         pv[0] <= memory_read_en;
         pa[0] <= memory_address;
         for (int i = 1; i < ML; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
         end
      end
   end

   assign memory_data_valid = pv[ML-1];
   assign memory_data = pv[ML-1] ? mem_word(pa[ML-1]) : '0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_quiet(input string p);
      chk({p, "_busy"}, 32'(fsm_busy), 0);
      chk({p, "_rd"}, 32'(memory_read_en), 0);
      chk({p, "_maddr"}, 32'(memory_address), 0);
      chk({p, "_wr"}, 32'(write_data_array), 0);
      chk({p, "_aaddr"}, 32'(array_addr), 0);
      chk({p, "_tagwe"}, 32'(write_tag_array), 0);
      chk({p, "_tag"}, 32'(tag_out), 0);
      chk({p, "_crit"}, 32'(critical_word_valid), 0);
      chk({p, "_wdata"}, 32'(array_wdata), 32'(memory_data));
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      bit            toggle;
      logic [AW-1:0] first_req;
      logic [AW-1:0] last_req;
      logic [TW-1:0] tag;
      int            crit_cyc;
   } vec_t;

   vec_t tbl [5];

   // call at a negedge in an idle cycle ("cycle 0"); returns at the
   // negedge of cycle 13, the first idle cycle after the fill
   task automatic run_fill(input int idx, input vec_t v);
      int n_req = 0, n_wr = 0, n_crit = 0, data_err = 0;
      int first_wr_cyc = -1, crit_cyc = -1, tag_cyc = -1;
      logic [AW-1:0] first_req = '0, last_req = '0;
      logic [AW-1:0] first_wr_addr = '0;
      logic [TW-1:0] tag_v = '0;
      logic [13:0]   busy_mask = '0;
      string p;
      p = $sformatf("v%0d", idx);
      miss_detected = 1'b1;
      miss_address  = v.addr;
      @(negedge clk);
      miss_detected = 1'b0;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         busy_mask[cyc] = fsm_busy;
         if (memory_read_en) begin
            n_req++;
            if (cyc == 1) first_req = memory_address;
            if (cyc == 8) last_req = memory_address;
         end
         if (write_data_array) begin
            n_wr++;
            if (first_wr_cyc < 0) begin
               first_wr_cyc  = cyc;
               first_wr_addr = array_addr;
            end
            if (array_wdata !== mem_word(array_addr)) data_err++;
         end
         if (critical_word_valid) begin
            n_crit++;
            crit_cyc = cyc;
         end
         if (write_tag_array) begin
            tag_cyc = cyc;
            tag_v   = tag_out;
         end
         if (v.toggle) begin
            miss_detected = (cyc >= 2 && cyc <= 9) ?
                            ~miss_detected : 1'b0;
            miss_address  = AW'($urandom);
         end
         if (cyc < 13) @(negedge clk);
      end
      chk({p, "_nreq"}, n_req, BW);
      chk({p, "_first_req"}, 32'(first_req), 32'(v.first_req));
      chk({p, "_last_req"}, 32'(last_req), 32'(v.last_req));
      chk({p, "_nwr"}, n_wr, BW);
      chk({p, "_first_wr_cyc"}, first_wr_cyc, 1 + ML);
      chk({p, "_first_wr_addr"}, 32'(first_wr_addr),
          32'(v.first_req));
      chk({p, "_ncrit"}, n_crit, 1);
      chk({p, "_crit_cyc"}, crit_cyc, v.crit_cyc);
      chk({p, "_tag_cyc"}, tag_cyc, BW + ML);
      chk({p, "_tag"}, 32'(tag_v), 32'(v.tag));
      chk({p, "_busy_mask"}, 32'(busy_mask), 32'h1FFE);
      chk({p, "_data"}, data_err, 0);
   endtask

   // reference: a fill is just "cycles since start" k in 0..BW+ML-1
   bit            r_act;
   int            r_k;
   logic [AW-1:0] r_b;
   int            r_c;

   function automatic int ord(input int i);
      return CWF ? (r_c + i) % BW : i;
   endfunction

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] ea;
      bit e_rd, e_wr, e_tag, e_crit;
      tbl[0] = '{16'h1236, 1'b0,
                 CWF ? 16'h1236 : 16'h1230,
                 CWF ? 16'h1234 : 16'h123E,
                 12'h123, CWF ? 5 : 8};
      tbl[1] = '{16'h4000, 1'b0, 16'h4000, 16'h400E,
                 12'h400, 5};
      tbl[2] = '{16'h123A, 1'b1,
                 CWF ? 16'h123A : 16'h1230,
                 CWF ? 16'h1238 : 16'h123E,
                 12'h123, CWF ? 5 : 10};
      tbl[3] = '{16'hFFFE, 1'b0,
                 CWF ? 16'hFFFE : 16'hFFF0,
                 CWF ? 16'hFFFC : 16'hFFFE,
                 12'hFFF, CWF ? 5 : 12};
      tbl[4] = '{16'h2002, 1'b0,
                 CWF ? 16'h2002 : 16'h2000,
                 CWF ? 16'h2000 : 16'h200E,
                 12'h200, CWF ? 5 : 6};

      rst = 1'b1;
      miss_detected = 1'b0;
      miss_address = '0;
      @(negedge clk);
      @(negedge clk);
      chk_quiet("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_fill(i, tbl[i]);

      // reset in cycle 6 of a fill
      miss_detected = 1'b1;
      miss_address  = 16'h1236;
      @(negedge clk);
      miss_detected = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst_busy_c6", 32'(fsm_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_quiet("midrst");
      rst = 1'b0;
      run_fill(4, tbl[4]);

      // random misses and resets against the reference model
      r_act = 1'b0;
      r_k = 0;
      r_b = '0;
      r_c = 0;
      for (int n = 0; n < 800; n++) begin
         e_rd   = r_act && (r_k < BW);
         e_wr   = r_act && (r_k >= ML);
         e_tag  = r_act && (r_k == BW + ML - 1);
         e_crit = e_wr && (ord(r_k - ML) == r_c);
         chk("rnd_busy", 32'(fsm_busy), 32'(r_act));
         chk("rnd_rd", 32'(memory_read_en), 32'(e_rd));
         chk("rnd_wr", 32'(write_data_array), 32'(e_wr));
         chk("rnd_tagwe", 32'(write_tag_array), 32'(e_tag));
         chk("rnd_crit", 32'(critical_word_valid), 32'(e_crit));
         if (e_rd) begin
            ea = r_b + AW'(2 * ord(r_k));
            chk("rnd_maddr", 32'(memory_address), 32'(ea));
         end
         if (e_wr) begin
            ea = r_b + AW'(2 * ord(r_k - ML));
            chk("rnd_aaddr", 32'(array_addr), 32'(ea));
            chk("rnd_wdata", 32'(array_wdata), 32'(mem_word(ea)));
         end
         if (e_tag) chk("rnd_tag", 32'(tag_out), 32'(r_b[15:4]));
         rst           = ($urandom_range(99) < 2);
         miss_detected = ($urandom_range(99) < 35);
         miss_address  = AW'($urandom);
         if (rst) begin
            r_act = 1'b0;
         end else if (r_act) begin
            if (r_k == BW + ML - 1) r_act = 1'b0;
            else r_k++;
         end else if (miss_detected) begin
            r_act = 1'b1;
            r_k   = 0;
            r_b   = miss_address & 16'hFFF0;
            r_c   = int'(miss_address[3:1]);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      miss_detected = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
